// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC operand loader: the default word width, the
// operand count, and the loader state encoding.
// -----------------------------------------------------------------------------
package mac_pkg;

   localparam int WIDTH   = 32;  // operand and result word width
   localparam int N_WORDS = 16;  // operand count; the loader is built for 16

   // LOAD: collecting operands, RUN: MAC stage running, DONE: result held
   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mac_operand_loader_if.sv
// -----------------------------------------------------------------------------
// mac_operand_loader_if
// Streaming-side bus of the operand loader: the serial operand input and the
// result output.
//
// Handshake: a word moves on a rising clock edge where valid and ready are both
// 1. The source holds data stable while valid is 1 and ready is 0; ready may
// depend on the sink's state but never on valid.
//
// Signals
//   in_data   [WIDTH] serial operand word          (master -> slave)
//   in_valid          in_data is valid             (master -> slave)
//   in_ready          loader accepts a word        (slave  -> master)
//   out_data  [WIDTH] captured result              (slave  -> master)
//   out_valid         out_data is valid            (slave  -> master)
//   out_ready         downstream accepts out_data  (master -> slave)
// -----------------------------------------------------------------------------
interface mac_operand_loader_if #(
   parameter int WIDTH = mac_pkg::WIDTH
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   // master: the surrounding system (operand source and result sink)
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   // slave: the loader itself
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/mac_operand_loader.sv
// -----------------------------------------------------------------------------
// mac_operand_loader
// Collects 16 serial operand words into a parallel register file, starts the
// MAC stage, captures its result and hands it downstream.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-high reset
//   bus        streaming bus (slave side): in_data/in_valid/in_ready for
//              operands, out_data/out_valid/out_ready for the result
//   abort      synchronous request to discard the current job
//   op_0..15   parallel operands; op_k is the k-th word accepted in the job
//   mac_start  registered start level, 1 exactly while in RUN
//   mac_valid  MAC stage result-ready flag (only looked at in RUN)
//   mac_x      MAC stage result
//   job_done   one-cycle pulse in the cycle the result is handed off
//   dbg_state  current FSM state for observation
// -----------------------------------------------------------------------------
module mac_operand_loader
   import mac_pkg::*;
#(
   parameter int WIDTH   = mac_pkg::WIDTH,
   parameter int N_WORDS = mac_pkg::N_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   mac_operand_loader_if.slave bus,
   input  logic              abort,
   output logic [WIDTH-1:0]  op_0,
   output logic [WIDTH-1:0]  op_1,
   output logic [WIDTH-1:0]  op_2,
   output logic [WIDTH-1:0]  op_3,
   output logic [WIDTH-1:0]  op_4,
   output logic [WIDTH-1:0]  op_5,
   output logic [WIDTH-1:0]  op_6,
   output logic [WIDTH-1:0]  op_7,
   output logic [WIDTH-1:0]  op_8,
   output logic [WIDTH-1:0]  op_9,
   output logic [WIDTH-1:0]  op_10,
   output logic [WIDTH-1:0]  op_11,
   output logic [WIDTH-1:0]  op_12,
   output logic [WIDTH-1:0]  op_13,
   output logic [WIDTH-1:0]  op_14,
   output logic [WIDTH-1:0]  op_15,
   output logic              mac_start,
   input  logic              mac_valid,
   input  logic [WIDTH-1:0]  mac_x,
   output logic              job_done,
   output state_t            dbg_state
);

   state_t           state_q, state_d;
   logic [3:0]       wr_idx_q, wr_idx_d;
   logic [WIDTH-1:0] op_q [N_WORDS];
   logic [WIDTH-1:0] op_d [N_WORDS];
   logic             mac_start_q, mac_start_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   // Next state, operand write-decode, result capture and hand-off pulse.
   // abort takes priority over every event of the current cycle: no operand
   // write, no capture and no job_done.
   always_comb begin
      state_d    = state_q;
      wr_idx_d   = wr_idx_q;
      op_d       = op_q;
      out_data_d = out_data_q;
      job_done   = 1'b0;

      if (abort) begin
         state_d  = LOAD;
         wr_idx_d = 4'd0;
      end else begin
         case (state_q)
            LOAD: begin
               if (bus.in_valid) begin
                  op_d[wr_idx_q] = bus.in_data;
                  // wraps to 0 after the last operand
                  wr_idx_d = wr_idx_q + 4'd1;
                  if (wr_idx_q == 4'(N_WORDS - 1)) begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               // waits for the MAC stage indefinitely; no timeout
               if (mac_valid) begin
                  out_data_d = mac_x;
                  state_d    = DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  job_done = 1'b1;
                  state_d  = LOAD;
               end
            end
            default: begin
               state_d  = LOAD;
               wr_idx_d = 4'd0;
            end
         endcase
      end

      // Registered start level that follows the state register exactly, so it
      // rises on the RUN entry edge and falls on the capture/abort edge.
      mac_start_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LOAD;
         wr_idx_q    <= 4'd0;
         mac_start_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < N_WORDS; i++) begin
            op_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         mac_start_q <= mac_start_d;
         out_data_q  <= out_data_d;
         op_q        <= op_d;
      end
   end

   assign bus.in_ready  = (state_q == LOAD);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;
   assign mac_start     = mac_start_q;
   assign dbg_state     = state_q;

   assign op_0  = op_q[0];
   assign op_1  = op_q[1];
   assign op_2  = op_q[2];
   assign op_3  = op_q[3];
   assign op_4  = op_q[4];
   assign op_5  = op_q[5];
   assign op_6  = op_q[6];
   assign op_7  = op_q[7];
   assign op_8  = op_q[8];
   assign op_9  = op_q[9];
   assign op_10 = op_q[10];
   assign op_11 = op_q[11];
   assign op_12 = op_q[12];
   assign op_13 = op_q[13];
   assign op_14 = op_q[14];
   assign op_15 = op_q[15];

endmodule

// File: tb/tb_mac_operand_loader.sv
module tb_mac_operand_loader;
  import mac_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  mac_operand_loader_if #(.WIDTH(W)) bus ();
  logic         abort;
  logic [W-1:0] op_w [16];
  logic         mac_start;
  logic         mac_valid;
  logic [W-1:0] mac_x;
  logic         job_done;
  state_t       dbg_state;

  mac_operand_loader #(.WIDTH(W), .N_WORDS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .abort     (abort),
    .op_0      (op_w[0]),
    .op_1      (op_w[1]),
    .op_2      (op_w[2]),
    .op_3      (op_w[3]),
    .op_4      (op_w[4]),
    .op_5      (op_w[5]),
    .op_6      (op_w[6]),
    .op_7      (op_w[7]),
    .op_8      (op_w[8]),
    .op_9      (op_w[9]),
    .op_10     (op_w[10]),
    .op_11     (op_w[11]),
    .op_12     (op_w[12]),
    .op_13     (op_w[13]),
    .op_14     (op_w[14]),
    .op_15     (op_w[15]),
    .mac_start (mac_start),
    .mac_valid (mac_valid),
    .mac_x     (mac_x),
    .job_done  (job_done),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [W-1:0] exp_q[$];   // results handed to the MAC stage, in order
  int jd_count  = 0;        // job_done pulses observed
  int ms_rise   = 0;        // mac_start rising edges observed
  int low_run   = 0;        // cycles mac_start has been low
  logic ms_prev = 1'b0;

  always @(negedge clk) begin
    if (job_done) begin
      jd_count++;
      if (exp_q.size() == 0) check_eq("extra_job_done", job_done, 1'b0);
      else check_eq("sb_out_data", bus.out_data, exp_q.pop_front());
    end
    if (mac_start && !ms_prev) begin
      if (ms_rise > 0) check_eq("start_gap_ge16", (low_run >= 16), 1'b1);
      ms_rise++;
    end
    if (mac_start) low_run = 0;
    else low_run++;
    ms_prev = mac_start;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    check_eq("in_ready_load", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_ops(input string tag, input logic [W-1:0] words [16]);
    for (int k = 0; k < 16; k++) check_eq(tag, op_w[k], words[k]);
  endtask

  // capture a result from the MAC stage and expect it downstream
  task automatic capture(input logic [W-1:0] x);
    mac_x     = x;
    mac_valid = 1'b1;
    exp_q.push_back(x);
    tick();
    mac_valid = 1'b0;
  endtask

  // hand the result off; job_done must appear within the cycle
  task automatic handoff();
    int base;
    base = jd_count;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("handoff_job_done", jd_count, base + 1);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] words [16];
  int bad;
  int rises0;
  int jobs_expected = 0;

  initial begin
    reset         = 1'b1;
    abort         = 1'b0;
    mac_valid     = 1'b0;
    mac_x         = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    // reset state, before any clock edge
    check_eq("rst_mac_start", mac_start, 1'b0);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_job_done", job_done, 1'b0);
    check_eq("rst_op0", op_w[0], 0);
    check_eq("rst_op15", op_w[15], 0);
    check_eq("rst_state", dbg_state, LOAD);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_in_ready", bus.in_ready, 1'b1);

    // words 1..16 back-to-back
    for (int i = 0; i < 16; i++) words[i] = W'(i + 1);
    for (int i = 0; i < 16; i++) send_word(words[i]);
    check_eq("full_in_ready_low", bus.in_ready, 1'b0);
    check_eq("full_mac_start", mac_start, 1'b1);
    check_eq("full_state_run", dbg_state, RUN);
    check_ops("full_ops", words);

    // RUN waits for mac_valid; operands frozen even with in_valid high
    bad = 0;
    for (int c = 0; c < 18; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFFFF_0000 | W'(c);
      tick();
      if (mac_start !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) bad++;
    end
    bus.in_valid = 1'b0;
    check_eq("run_hold", bad, 0);
    check_ops("run_frozen", words);
    capture(32'h0000_0550);
    check_eq("cap_out_valid", bus.out_valid, 1'b1);
    check_eq("cap_out_data", bus.out_data, 32'h550);
    check_eq("cap_mac_start", mac_start, 1'b0);

    // DONE holds the result while out_ready is low
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      mac_valid = 1'b1;  // ignored outside RUN
      mac_x     = 32'hDEAD_0000 | W'(c);
      tick();
      if (bus.out_data !== 32'h550 || bus.out_valid !== 1'b1 || job_done !== 1'b0) bad++;
    end
    mac_valid = 1'b0;
    check_eq("done_stable", bad, 0);
    bus.out_ready = 1'b1;
    #1;
    check_eq("done_job_done_pulse", job_done, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    jobs_expected++;
    check_eq("after_done_job_done", job_done, 1'b0);
    check_eq("after_done_in_ready", bus.in_ready, 1'b1);
    check_eq("after_done_out_valid", bus.out_valid, 1'b0);
    check_eq("jd_count_1", jd_count, 1);

    // partial load, abort coinciding with a transfer, then a fresh job
    for (int i = 0; i < 7; i++) send_word(32'hA0 + W'(i));
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("abort_in_ready", bus.in_ready, 1'b1);
    check_eq("abort_no_write_op7", op_w[7], 32'd8);
    check_eq("abort_keep_op6", op_w[6], 32'hA6);
    check_eq("abort_mac_start", mac_start, 1'b0);
    rises0 = ms_rise;
    for (int i = 0; i < 16; i++) words[i] = 32'hB0 + W'(i);
    for (int i = 0; i < 16; i++) send_word(words[i]);
    check_ops("reload_ops", words);
    check_eq("reload_mac_start", mac_start, 1'b1);
    // abort in RUN wins over mac_valid: no capture
    abort     = 1'b1;
    mac_valid = 1'b1;
    mac_x     = 32'h0BAD;
    tick();
    abort     = 1'b0;
    mac_valid = 1'b0;
    check_eq("abort_run_rises", ms_rise - rises0, 1);
    check_eq("abort_run_out_valid", bus.out_valid, 1'b0);
    check_eq("abort_run_mac_start", mac_start, 1'b0);
    check_eq("abort_run_in_ready", bus.in_ready, 1'b1);

    // abort in DONE wins over out_ready: no job_done
    for (int i = 0; i < 16; i++) send_word(32'hC0 + W'(i));
    mac_x     = 32'h1234;
    mac_valid = 1'b1;
    tick();
    mac_valid = 1'b0;
    check_eq("c_out_data", bus.out_data, 32'h1234);
    abort         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_eq("abort_done_no_pulse", job_done, 1'b0);
    tick();
    abort         = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("abort_done_out_valid", bus.out_valid, 1'b0);
    check_eq("abort_done_jd_count", jd_count, 1);

    // reset while in RUN acts without a clock edge
    for (int i = 0; i < 16; i++) send_word(32'hD0 + W'(i));
    check_eq("rrun_mac_start", mac_start, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("rrun_async_mac_start", mac_start, 1'b0);
    check_eq("rrun_async_out_valid", bus.out_valid, 1'b0);
    check_eq("rrun_async_out_data", bus.out_data, 0);
    check_eq("rrun_async_op0", op_w[0], 0);
    @(negedge clk);
    reset = 1'b0;
    mac_valid = 1'b1;
    mac_x     = 32'h0777;
    tick();
    mac_valid = 1'b0;
    check_eq("rrun_no_capture", bus.out_valid, 1'b0);
    check_eq("rrun_in_ready", bus.in_ready, 1'b1);
    tick();
    check_eq("rrun_no_capture2", bus.out_valid, 1'b0);

    // randomized jobs with gaps, ignored inputs and occasional aborts
    for (int j = 0; j < 100; j++) begin
      int abort_at;
      logic [W-1:0] x;
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 0;
      for (int i = 0; i < abort_at; i++) send_word($urandom);
      if (abort_at > 0) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      for (int i = 0; i < 16; i++) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          mac_valid    = 1'($urandom_range(0, 1));
          mac_x        = $urandom;
          tick();
        end
        mac_valid = 1'b0;
        send_word(words[i]);
      end
      check_ops("rnd_ops", words);
      for (int g = 0, n = $urandom_range(0, 5); g < n; g++) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = $urandom;
        tick();
      end
      bus.in_valid = 1'b0;
      x = $urandom;
      capture(x);
      for (int g = 0, n = $urandom_range(0, 3); g < n; g++) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = $urandom;
        mac_valid    = 1'($urandom_range(0, 1));
        mac_x        = $urandom;
        tick();
      end
      bus.in_valid = 1'b0;
      mac_valid    = 1'b0;
      check_ops("rnd_frozen", words);
      check_eq("rnd_out_valid", bus.out_valid, 1'b1);
      handoff();
      jobs_expected++;
    end

    tick();
    tick();
    check_eq("sb_leftover", exp_q.size(), 0);
    check_eq("job_done_count", jd_count, jobs_expected);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mac_operand_loader.md
MAC_OPERAND_LOADER -- requirements
Module: mac_operand_loader

Interface
REQ-001 Parameter: WIDTH, default 32, word width of each operand and of the result.
REQ-002 Parameter: N_WORDS, default 16, operand count; fixed at 16, and changing it is unsupported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  serial operand word.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts a word this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 abort  input  1  synchronous request to discard the current job.
REQ-009 op_0 .. op_15  output  WIDTH each  parallel operands to the MAC stage; op_k holds the k-th word accepted in the job.
REQ-010 mac_start  output  1  start level to the MAC stage.
REQ-011 mac_valid  input  1  MAC stage result-ready flag.
REQ-012 mac_x  input  WIDTH  MAC stage result.
REQ-013 out_data  output  WIDTH  captured result.
REQ-014 out_valid  output  1  out_data is valid.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 job_done  output  1  one-cycle pulse when a result is handed off downstream.

Function
REQ-017 The FSM SHALL have three states: LOAD, RUN and DONE.
REQ-018 In LOAD, in_ready SHALL be 1, and each transfer SHALL write in_data to op_[wr_idx] and increment the 4-bit wr_idx.
REQ-019 The transfer at wr_idx=15 SHALL go to RUN on the next cycle and wrap wr_idx to 0.
REQ-020 In RUN and DONE, in_ready SHALL be 0 and op_0..op_15 SHALL remain frozen.
REQ-021 mac_start SHALL be a registered output that is 1 exactly while in RUN.
REQ-022 In RUN with mac_valid=1, the loader SHALL capture mac_x into out_data and go to DONE; mac_start SHALL fall on the same edge.
REQ-023 mac_valid SHALL be ignored outside RUN.
REQ-024 In DONE, out_valid SHALL be 1 and out_data SHALL be stable.
REQ-025 In DONE with out_ready=1, the loader SHALL go to LOAD and pulse job_done in that cycle.
REQ-026 mac_start SHALL be 0 for at least 16 cycles between jobs, which guarantees the MAC stage counter clears.
REQ-027 There SHALL be no RUN timeout; the loader waits for mac_valid indefinitely.
REQ-028 abort=1 in any state SHALL force LOAD, set wr_idx=0, mac_start=0 and out_valid=0 on the next edge; op_* contents are retained but are overwritten by the next job.
REQ-029 When abort and a transfer, mac_valid or out_ready coincide, abort SHALL win: no write, no capture and no job_done.
REQ-030 A partial load (fewer than 16 words) SHALL persist across idle in_valid gaps; wr_idx advances only on transfers.
REQ-031 Results SHALL be passed through unmodified: no arithmetic and no width change.

Reset
REQ-032 Asserting reset SHALL immediately set state=LOAD, wr_idx=0, mac_start=0, out_valid=0, job_done=0, out_data=0 and op_0..op_15=0.
REQ-033 After reset deasserts, in_ready SHALL be 1 combinationally from state.
REQ-034 Reset mid-RUN SHALL drop mac_start asynchronously, and no result from that job SHALL be captured.

Structure
REQ-035 A shared package mac_pkg SHALL hold WIDTH, N_WORDS and the state enum (LOAD, RUN, DONE).
REQ-036 The block SHALL be one module with no sub-modules; the operand file is 16 registers with a write-decode from wr_idx.
REQ-037 The top level SHALL wire op_0..op_15, mac_start, mac_valid and mac_x directly to the MAC stage a_0..a_15, start, valid and x_15.

Verification
REQ-038 Reset, then feed words 1..16 back-to-back -> in_ready falls after the 16th word; op_0=1 .. op_15=16; mac_start=1 the next cycle.
REQ-039 In RUN, hold mac_valid=0 for 18 cycles, then drive mac_valid=1 with mac_x=0x0000_0550 -> out_valid=1 and out_data=0x550 on the next cycle; mac_start=0.
REQ-040 In DONE, hold out_ready=0 for 5 cycles, then set it to 1 -> out_data stays stable; job_done pulses once; in_ready=1 the following cycle.
REQ-041 Load 7 words, assert abort for one cycle, then load 16 new words -> op_0..op_15 equal the new words and mac_start rises once.
REQ-042 Assert reset while in RUN -> mac_start=0 and out_valid=0 with no clock edge; an mac_valid pulse afterwards produces no out_valid.
REQ-043 Random in_valid gaps over 100 jobs, compared against a scoreboard -> each out_data equals the mac_x given per job; no extra or lost job_done pulses.
